ifmap_fifo: RTL

- Byte-granular input-feature-map FIFO between the ifmap FIFO controller (producer/pop requester) and one PE-array row input (consumer).
- Accepts single-byte pushes or 4-byte burst pushes from the controller, selected by push mode.
- Presents the head byte first-word-fall-through to the PE array.
- Reports full/empty/occupancy back to the controller.

---
 rtl/ifmap_fifo.sv | 100 ++++++++++
 1 files changed

// File: rtl/ifmap_fifo.sv
// Byte-granular ifmap FIFO feeding one PE-array row: single-byte or 4-byte burst
// pushes, first-word-fall-through head byte, occupancy and sticky error flags.
module ifmap_fifo #(
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fifo_reset_i,
    input  logic             push_i,
    input  logic             push_mod_i,
    input  logic [31:0]      push_data_i,
    input  logic             pop_i,
    output logic [7:0]       pop_data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             burst_ready_o,
    output logic [CNT_W-1:0] count_o,
    output logic             overflow_o,
    output logic             underflow_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic             overflow;
    logic             underflow;

    logic             clear;
    logic [CNT_W-1:0] push_len;
    logic [CNT_W-1:0] free_slots;
    logic             push_ok;
    logic             pop_ok;
    logic [CNT_W-1:0] count_next;

    assign clear      = !rst_n || fifo_reset_i;
    assign push_len   = push_mod_i ? CNT_W'(4) : CNT_W'(1);
    assign free_slots = CNT_W'(DEPTH) - count;

    // Room is judged on the pre-pop count, so a same-cycle pop never makes space.
    assign push_ok    = push_i && (free_slots >= push_len);
    assign pop_ok     = pop_i && (count != '0);

    always_comb begin
        count_next = count;
        if (push_ok) begin
            count_next = count_next + push_len;
        end
        if (pop_ok) begin
            count_next = count_next - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            count <= count_next;
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(push_len);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push_i && !push_ok) begin
                overflow <= 1'b1;
            end
            if (pop_i && !pop_ok) begin
                underflow <= 1'b1;
            end
        end
    end

    // Storage is never cleared; a burst writes all four lanes or none.
    always_ff @(posedge clk) begin
        if (!clear && push_ok) begin
            for (int k = 0; k < 4; k++) begin
                if (k == 0 || push_mod_i) begin
                    mem[wr_ptr + PTR_W'(k)] <= push_data_i[8*k +: 8];
                end
            end
        end
    end

    assign pop_data_o    = (count == '0) ? 8'h00 : mem[rd_ptr];
    assign full_o        = (count == CNT_W'(DEPTH));
    assign empty_o       = (count == '0);
    assign burst_ready_o = (free_slots >= CNT_W'(4));
    assign count_o       = count;
    assign overflow_o    = overflow;
    assign underflow_o   = underflow;

endmodule
